// File: rtl/yavar_ctr_pkg.sv
// Shared types and helpers for the yavar up/down counter.
// Optional feature macro used by the counter top: YAVAR_CTR_OVF_STICKY_EN.
package yavar_ctr_pkg;

  // Counting direction as seen on the 'up' input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Behaviour at a bound as seen on the 'sat_mode' input.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Largest supported enable divider.
  localparam int unsigned PRESCALE_MAX = 32'd256;

  // Bits needed to hold 0..value-1, never less than one.
  // A zero-width prescaler counter is not legal, so PRESCALE=1 still gets one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned bits;
    bits = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        bits = i + 32'd1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/yavar_ctr_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles.
// The tick is combinational from en; the counter consuming it registers its result.
module yavar_ctr_prescaler
  import yavar_ctr_pkg::*;
#(
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  // A period completes on the last enabled cycle of the divider.
  assign tick = en && (pcnt_q == LAST);

  // Next divider phase: clear beats tick, tick restarts, enable advances, else hold.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = {PW{1'b0}};
    end else if (tick) begin
      pcnt_d = {PW{1'b0}};
    end else if (en) begin
      pcnt_d = pcnt_q + PW'(1'b1);
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Divider phase register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= {PW{1'b0}};
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/yavar_updown_counter.sv
// Parametrised up/down counter with programmable terminal value, load,
// wrap/saturate mode, enable prescaler and a one-cycle terminal-count pulse.
// Optional macro YAVAR_CTR_OVF_STICKY_EN adds ovf_clr/ovf (sticky overflow).
module yavar_updown_counter
  import yavar_ctr_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd8,
  parameter int unsigned MAX_VAL  = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
`ifdef YAVAR_CTR_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             tick_s;
  dir_e             dir_s;
  mode_e            mode_s;

  assign dir_s  = dir_e'(up);
  assign mode_s = mode_e'(sat_mode);

  // A load restarts the prescaler so the next full period begins after it.
  yavar_ctr_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick_s)
  );

  // Next count and terminal pulse: load beats tick; bounds are tested before +/-1.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      if (load_val > MAX_V) begin
        count_d = MAX_V;
      end else begin
        count_d = load_val;
      end
      tc_d = 1'b0;
    end else if (tick_s) begin
      case (dir_s)
        DIR_UP: begin
          if (count_q == MAX_V) begin
            tc_d    = 1'b1;
            count_d = (mode_s == MODE_SAT) ? MAX_V : ZERO_V;
          end else begin
            count_d = count_q + ONE_V;
          end
        end
        DIR_DOWN: begin
          if (count_q == ZERO_V) begin
            tc_d    = 1'b1;
            count_d = (mode_s == MODE_SAT) ? ZERO_V : MAX_V;
          end else begin
            count_d = count_q - ONE_V;
          end
        end
        default: begin
          count_d = count_q;
          tc_d    = 1'b0;
        end
      endcase
    end else begin
      count_d = count_q;
      tc_d    = 1'b0;
    end
  end

  // Count and terminal-pulse registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO_V;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

`ifdef YAVAR_CTR_OVF_STICKY_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky overflow: sets with tc (winning over a clear), else clears on ovf_clr.
  always_comb begin
    ovf_d = ovf_q;
    if (tc_d) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_yavar_updown_counter.sv
// Self-checking bench for yavar_updown_counter: two instances (PRESCALE 1 and 3,
// WIDTH=4, MAX_VAL=9) share stimulus; a cycle model checks both every cycle and
// directed literal expectations pin the model.
module tb_yavar_updown_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, sat_mode, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] a_count, b_count;
  logic       a_tc, b_tc;
`ifdef YAVAR_CTR_OVF_STICKY_EN
  logic       a_ovf, b_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  yavar_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .count(a_count), .tc(a_tc)
`ifdef YAVAR_CTR_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(a_ovf)
`endif
  );

  yavar_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
    .load_val(load_val), .count(b_count), .tc(b_tc)
`ifdef YAVAR_CTR_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(b_ovf)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int cnt;    // current count value
    int phase;  // enabled cycles seen since the last period boundary
    bit tc;
    bit ovf;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, int pre, bit e, bit u, bit sat,
                                    bit l, int lv, bit oclr);
    mstate_t n;
    bit      fire;
    n      = s;
    n.tc   = 1'b0;
    fire   = e && ((s.phase + 1) == pre);
    if (l) begin
      n.cnt   = (lv > MAXV) ? MAXV : lv;
      n.phase = 0;
    end else begin
      if (e) n.phase = (s.phase + 1) % pre;
      if (fire) begin
        if (u) begin
          if (s.cnt == MAXV) begin n.tc = 1'b1; n.cnt = sat ? MAXV : 0; end
          else n.cnt = s.cnt + 1;
        end else begin
          if (s.cnt == 0) begin n.tc = 1'b1; n.cnt = sat ? 0 : MAXV; end
          else n.cnt = s.cnt - 1;
        end
      end
    end
    n.ovf = n.tc ? 1'b1 : (oclr ? 1'b0 : s.ovf);
    return n;
  endfunction

  // Model state follows the DUT clock and asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{cnt: 0, phase: 0, tc: 1'b0, ovf: 1'b0};
      mb <= '{cnt: 0, phase: 0, tc: 1'b0, ovf: 1'b0};
    end else begin
      ma <= mstep(ma, 1, en, up, sat_mode, load, int'(load_val), ovf_clr);
      mb <= mstep(mb, 3, en, up, sat_mode, load, int'(load_val), ovf_clr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("model_a_count", 32'(a_count), 32'(ma.cnt));
      check("model_a_tc",    32'(a_tc),    32'(ma.tc));
      check("model_b_count", 32'(b_count), 32'(mb.cnt));
      check("model_b_tc",    32'(b_tc),    32'(mb.tc));
`ifdef YAVAR_CTR_OVF_STICKY_EN
      check("model_a_ovf",   32'(a_ovf),   32'(ma.ovf));
      check("model_b_ovf",   32'(b_ovf),   32'(mb.ovf));
`endif
    end
  end

  // Apply one cycle of inputs and return at the following falling edge.
  task automatic cyc(input logic e, input logic u, input logic s, input logic l,
                     input logic [3:0] v);
    en = e; up = u; sat_mode = s; load = l; load_val = v;
    @(negedge clk);
  endtask

  int up_exp   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_exp   [4]  = '{1, 0, 9, 8};
  int dn_tc    [4]  = '{0, 0, 1, 0};
  int sat_exp  [4]  = '{1, 0, 0, 0};
  int sat_tc   [4]  = '{0, 0, 1, 1};

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
    load_val = 4'd0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_a_count", 32'(a_count), 32'd0);
    check("reset_a_tc",    32'(a_tc),    32'd0);
    check("reset_b_count", 32'(b_count), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Up, wrap, 12 enabled cycles.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("up_wrap_count", 32'(a_count), 32'(up_exp[i]));
      check("up_wrap_tc",    32'(a_tc),    (i == 9) ? 32'd1 : 32'd0);
    end
    check("presc3_after12", 32'(b_count), 32'd4);

    // Down, wrap, from 2.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    check("load2_count", 32'(a_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      check("down_wrap_count", 32'(a_count), 32'(dn_exp[i]));
      check("down_wrap_tc",    32'(a_tc),    32'(dn_tc[i]));
    end

    // Down, saturate, from 2.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      check("down_sat_count", 32'(a_count), 32'(sat_exp[i]));
      check("down_sat_tc",    32'(a_tc),    32'(sat_tc[i]));
    end

    // Clamped load with a simultaneous tick on both instances.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    check("clamp_a_count", 32'(a_count), 32'd9);
    check("clamp_a_tc",    32'(a_tc),    32'd0);
    check("clamp_b_count", 32'(b_count), 32'd9);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("after_clamp_a_wrap", 32'(a_count), 32'd0);
    check("after_clamp_a_tc",   32'(a_tc),    32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("presc_restart_hold", 32'(b_count), 32'd9);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("presc_restart_wrap", 32'(b_count), 32'd0);
    check("presc_restart_tc",   32'(b_tc),    32'd1);

    // Prescaler with en dropped for two cycles mid-period.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("en_gap_not_yet", 32'(b_count), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("en_gap_delayed", 32'(b_count), 32'd1);

    // Asynchronous reset mid-count at 7.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("pre_reset_count", 32'(a_count), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_a_count", 32'(a_count), 32'd0);
    check("async_rst_a_tc",    32'(a_tc),    32'd0);
    check("async_rst_b_count", 32'(b_count), 32'd0);
    #1 rst = 1'b0;
    en = 1'b1; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
    @(negedge clk);
    check("resume_after_rst", 32'(a_count), 32'd1);

`ifdef YAVAR_CTR_OVF_STICKY_EN
    // Sticky overflow set, hold, set-beats-clear, clear.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    check("ovf_clear_after_rst", 32'(a_ovf), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("ovf_set", 32'(a_ovf), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("ovf_sticky", 32'(a_ovf), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    ovf_clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    check("ovf_set_beats_clr", 32'(a_ovf), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("ovf_cleared", 32'(a_ovf), 32'd0);
    ovf_clr = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
`endif

    // A few mixed cycles for the per-cycle model comparison.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd8);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check("sat_up_hold", 32'(a_count), 32'd9);
    check("sat_up_tc",   32'(a_tc),    32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
